fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the team's synchronous FIFO between N independent producers. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst and forwards its beats to the FIFO write port. It never issues a write while the FIFO reports full, so the FIFO's overflow flag must stay low in any system built with this block.

---
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin sharing of one FIFO write port among N_REQ valid/ready producers, bounded bursts.
// Latency: a grant is registered one cycle after a valid is seen in IDLE; data and enable to the FIFO are combinational.
// Backpressure: fifo_full_i clears the granted port's ready and the write enable; the grant is held, without counting, while full.
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [N_REQ-1:0]        req_valid_i,
   input  logic [N_REQ*DATA_W-1:0] req_data_i,
   output logic [N_REQ-1:0]        req_ready_o,
   input  logic                    fifo_full_i,
   output logic                    fifo_wr_en_o,
   output logic [DATA_W-1:0]       fifo_wr_data_o,
   output logic [N_REQ-1:0]        grant_o,
   output logic [ID_W-1:0]         grant_id_o,
   output logic                    busy_o
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t             r_state;
   logic [ID_W-1:0]    r_grant_id;
   logic [ID_W-1:0]    r_last_id;
   logic [N_REQ-1:0]   r_grant;
   logic [CNT_W-1:0]   r_beat_cnt;

   logic               w_any;
   logic               w_hi;
   logic [ID_W-1:0]    w_pick_lo;
   logic [ID_W-1:0]    w_pick_hi;
   logic [ID_W-1:0]    w_pick;
   logic               w_g_vld;
   logic [DATA_W-1:0]  w_g_dat;
   logic               w_busy;
   logic               w_wr_en;
   logic               w_last_beat;
   logic               w_release;

   // Rotating priority: lowest valid port above last_id wins, else wrap to the lowest valid port overall.
   always_comb begin
      w_any     = 1'b0;
      w_hi      = 1'b0;
      w_pick_lo = '0;
      w_pick_hi = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_valid_i[k]) begin
            w_any     = 1'b1;
            w_pick_lo = ID_W'(k);
            if (ID_W'(k) > r_last_id) begin
               w_hi      = 1'b1;
               w_pick_hi = ID_W'(k);
            end
         end
      end
      w_pick = w_hi ? w_pick_hi : w_pick_lo;
   end

   // Select valid and data of the currently granted port.
   always_comb begin
      w_g_vld = 1'b0;
      w_g_dat = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (r_grant_id == ID_W'(k)) begin
            w_g_vld = req_valid_i[k];
            w_g_dat = req_data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   assign w_busy      = (r_state == S_GRANT);
   assign w_wr_en     = w_busy && w_g_vld && !fifo_full_i;
   assign w_last_beat = w_wr_en && (r_beat_cnt == CNT_W'(MAX_BURST - 1));
   // A granted producer that drops valid has ended its burst, even while the FIFO is full.
   assign w_release   = w_last_beat || !w_g_vld;

   assign req_ready_o    = (w_busy && !fifo_full_i) ? r_grant : '0;
   assign fifo_wr_en_o   = w_wr_en;
   assign fifo_wr_data_o = w_busy ? w_g_dat : '0;
   assign grant_o        = r_grant;
   assign grant_id_o     = r_grant_id;
   assign busy_o         = w_busy;

   // Grant/release state machine with burst counting; last_id resets to the top port so port 0 goes first.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_grant_id <= '0;
         r_last_id  <= ID_W'(N_REQ - 1);
         r_grant    <= '0;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state    <= S_GRANT;
                  r_grant_id <= w_pick;
                  r_grant    <= N_REQ'(1) << w_pick;
                  r_beat_cnt <= '0;
               end
            end
            S_GRANT: begin
               if (w_release) begin
                  r_state    <= S_IDLE;
                  r_last_id  <= r_grant_id;
                  r_grant_id <= '0;
                  r_grant    <= '0;
                  r_beat_cnt <= '0;
               end else if (w_wr_en) begin
                  r_beat_cnt <= r_beat_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producers with per-port expected queues, a depth-16 FIFO occupancy model,
// and a negedge monitor that checks every write against the issuing port's queue order.
module tb_fifo_wr_arbiter;
   localparam int N     = 4;
   localparam int W     = 8;
   localparam int MB    = 4;
   localparam int DEPTH = 16;
   localparam int IDW   = 2;

   logic           clk    = 1'b0;
   logic           rst_ni = 1'b0;
   logic [N-1:0]   vld    = '0;
   logic [N*W-1:0] dat    = '0;
   logic [N-1:0]   req_ready_o;
   logic [N-1:0]   grant_o;
   logic           fifo_full_i;
   logic           fifo_wr_en_o;
   logic           busy_o;
   logic [W-1:0]   fifo_wr_data_o;
   logic [IDW-1:0] grant_id_o;

   logic force_full = 1'b0;
   logic gap_en     = 1'b0;
   int   fcnt       = 0;
   int   fcnt_nxt   = 0;
   int   rd_mode    = 1;
   int   cur_beats  = 0;
   int   n_vec      = 0;
   int   n_err      = 0;

   logic [W-1:0] exp_q [N][$];
   int           rem   [N];
   logic [5:0]   seq   [N];
   int           beats [N];

   logic           s_busy  = 1'b0;
   logic           s_wr    = 1'b0;
   logic [IDW-1:0] s_gid   = '0;
   logic [N-1:0]   s_grant = '0;
   logic [N-1:0]   s_ready = '0;

   int t1_b [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
   int t1_w [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
   int t4_b [5]  = '{0, 1, 1, 0, 1};
   int t4_g [5]  = '{0, 8, 8, 0, 1};
   int t4_w [5]  = '{0, 1, 0, 0, 1};

   always #5 clk = ~clk;

   assign fifo_full_i = force_full || (fcnt >= DEPTH);

   fifo_wr_arbiter #(
      .N_REQ     (N),
      .DATA_W    (W),
      .MAX_BURST (MB)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .req_valid_i    (vld),
      .req_data_i     (dat),
      .req_ready_o    (req_ready_o),
      .fifo_full_i    (fifo_full_i),
      .fifo_wr_en_o   (fifo_wr_en_o),
      .fifo_wr_data_o (fifo_wr_data_o),
      .grant_o        (grant_o),
      .grant_id_o     (grant_id_o),
      .busy_o         (busy_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Producer k offers its next beat; data carries the port number in the top bits.
   task automatic present(input int k);
      logic [W-1:0] d;
      d = {2'(k), seq[k]};
      seq[k] = seq[k] + 6'd1;
      dat[k*W +: W] = d;
      exp_q[k].push_back(d);
      vld[k] = 1'b1;
   endtask

   task automatic load(input int k, input int n);
      rem[k] = n;
      if (!vld[k]) present(k);
   endtask

   // One clock: sample at negedge, then advance producers just after the rising edge.
   task automatic tick();
      logic [N-1:0] took;
      @(negedge clk);
      took    = vld & req_ready_o;
      s_busy  = busy_o;
      s_wr    = fifo_wr_en_o;
      s_gid   = grant_id_o;
      s_grant = grant_o;
      s_ready = req_ready_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         if (took[k]) begin
            vld[k] = 1'b0;
            rem[k]--;
            beats[k]++;
         end
         if (!vld[k] && rem[k] > 0 && (!gap_en || $urandom_range(0, 3) != 0)) present(k);
      end
   endtask

   // Let pending beats finish, offer nothing new, wait for the arbiter to go idle.
   task automatic drain(input int bound);
      for (int k = 0; k < N; k++) rem[k] = vld[k] ? 1 : 0;
      for (int i = 0; i < bound && (vld != '0 || s_busy); i++) tick();
      chk("drain_done", 32'(vld != '0 || s_busy), 32'd0);
   endtask

   // Monitor: every FIFO write must be the oldest outstanding beat of its port; FIFO occupancy model.
   always @(negedge clk) begin : monitor
      logic [IDW-1:0] p;
      logic           rd;
      if (rst_ni) begin
         chk("grant_match", 32'(grant_o), busy_o ? (32'd1 << grant_id_o) : 32'd0);
         if (!busy_o)
            chk("idle_quiet", {23'd0, fifo_wr_en_o, req_ready_o, 4'd0} | 32'(fifo_wr_data_o), 32'd0);
         if (fifo_wr_en_o) begin
            chk("overflow", 32'(fifo_full_i), 32'd0);
            p = fifo_wr_data_o[W-1 -: IDW];
            chk("wr_port", 32'(p), 32'(grant_id_o));
            chk("wr_expected", 32'(exp_q[p].size() != 0), 32'd1);
            if (exp_q[p].size() != 0) chk("wr_data", 32'(fifo_wr_data_o), 32'(exp_q[p].pop_front()));
            cur_beats++;
            chk("burst_len", 32'(cur_beats > MB), 32'd0);
         end
         if (!busy_o) cur_beats = 0;
         rd = (rd_mode == 1 || (rd_mode == 2 && $urandom_range(0, 1) == 1)) && fcnt > 0;
         fcnt_nxt = fcnt + (fifo_wr_en_o ? 1 : 0) - (rd ? 1 : 0);
      end
   end

   always @(posedge clk) fcnt <= fcnt_nxt;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1, "timeout");
   end

   initial begin : main
      int exp_id;
      int nstarts;
      logic pb;
      for (int k = 0; k < N; k++) begin
         rem[k] = 0; seq[k] = '0; beats[k] = 0;
      end

      // Reset values
      @(negedge clk);
      chk("rst_grant", 32'(grant_o), 32'd0);
      chk("rst_grant_id", 32'(grant_id_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk);
      #1 rst_ni = 1'b1;
      tick();

      // Single producer, 6 beats on port 2: 4-beat burst, one idle cycle, then 2 beats
      load(2, 6);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t1_busy", 32'(s_busy), 32'(t1_b[i]));
         chk("t1_wr_en", 32'(s_wr), 32'(t1_w[i]));
         chk("t1_grant_id", 32'(s_gid), (t1_b[i] != 0) ? 32'd2 : 32'd0);
      end

      // All ports continuously valid: rotation continues after port 2, equal share
      for (int k = 0; k < N; k++) beats[k] = 0;
      for (int k = 0; k < N; k++) load(k, 20);
      exp_id  = 3;
      nstarts = 0;
      pb      = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (s_busy && !pb) begin
            chk("t2_rotation", 32'(s_gid), 32'(exp_id));
            exp_id = (exp_id + 1) % N;
            nstarts++;
         end
         pb = s_busy;
      end
      chk("t2_grants", 32'(nstarts), 32'd16);
      for (int k = 0; k < N; k++) chk("t2_beats_per_port", 32'(beats[k]), 32'd16);
      drain(100);

      // Backpressure mid-burst on port 1
      load(1, 4);
      tick();
      chk("t3_idle", 32'(s_busy), 32'd0);
      tick();
      chk("t3_beat1", 32'(s_wr), 32'd1);
      tick();
      chk("t3_beat2", 32'(s_wr), 32'd1);
      force_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_full_ready", 32'(s_ready[1]), 32'd0);
         chk("t3_full_wr_en", 32'(s_wr), 32'd0);
         chk("t3_full_hold", {30'd0, s_busy, 1'b0} | 32'(s_gid), 32'd3);
      end
      force_full = 1'b0;
      tick();
      chk("t3_beat3", 32'(s_wr), 32'd1);
      tick();
      chk("t3_beat4", 32'(s_wr), 32'd1);
      tick();
      chk("t3_release", 32'(s_busy), 32'd0);
      drain(20);

      // Early release: port 3 one beat, port 0 also waiting
      load(0, 2);
      load(3, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_busy", 32'(s_busy), 32'(t4_b[i]));
         chk("t4_grant", 32'(s_grant), 32'(t4_g[i]));
         chk("t4_wr_en", 32'(s_wr), 32'(t4_w[i]));
      end
      drain(30);

      // Asynchronous reset during the third beat of port 1
      load(1, 6);
      tick();
      tick();
      tick();
      #2 rst_ni = 1'b0;
      #1;
      chk("t5_rst_grant", 32'(grant_o), 32'd0);
      chk("t5_rst_busy", 32'(busy_o), 32'd0);
      chk("t5_rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
      chk("t5_inflight_unwritten", 32'(exp_q[1].size()), 32'd1);
      vld = '0;
      for (int k = 0; k < N; k++) begin
         rem[k] = 0;
         exp_q[k].delete();
      end
      s_busy = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_ni = 1'b1;
      load(0, 1);
      load(1, 1);
      tick();
      chk("t5_idle", 32'(s_busy), 32'd0);
      tick();
      chk("t5_port0_first", 32'(s_grant), 32'd1);
      drain(20);

      // Random traffic against the FIFO model with random reads
      gap_en  = 1'b1;
      rd_mode = 2;
      for (int i = 0; i < 2000; i++) begin
         for (int k = 0; k < N; k++)
            if (rem[k] == 0 && !vld[k] && $urandom_range(0, 3) == 0) load(k, int'($urandom_range(1, 8)));
         tick();
      end
      gap_en  = 1'b0;
      rd_mode = 1;
      drain(400);
      for (int k = 0; k < N; k++) chk("t6_all_written", 32'(exp_q[k].size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
